// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   - Default address/data widths for the shared data memory.
//   - Port-ID encoding used for grant tracking and return routing (fetch = 0, data = 1).
//   - Width of the conflict counter and its saturating increment.
package mem_arbiter_pkg;

  localparam int unsigned AddrWDefault = 10;
  localparam int unsigned DataWDefault = 32;
  localparam int unsigned CntW         = 16;

  typedef enum logic {
    PortIf = 1'b0,
    PortDm = 1'b1
  } port_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + CntW'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between the fetch port and the data port.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_if, req_dm  : requests from fetch and data ports
//   gnt_if, gnt_dm  : combinational one-hot (or zero) grants, forced low in reset
//   conflict        : both ports requesting in this (non-reset) cycle
// The pointer remembers the winner of the most recent conflict and only moves on conflicts,
// so an uncontested request never disturbs the fairness order.
module mem_arbiter_rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_dm,
  output logic gnt_if,
  output logic gnt_dm,
  output logic conflict
);

  port_e last_conf_q;

  always_comb begin
    gnt_if   = 1'b0;
    gnt_dm   = 1'b0;
    conflict = rst_n & req_if & req_dm;
    if (rst_n) begin
      if (req_if && req_dm) begin
        gnt_if = (last_conf_q == PortDm);
        gnt_dm = (last_conf_q == PortIf);
      end else begin
        gnt_if = req_if;
        gnt_dm = req_dm;
      end
    end
  end

  // Reset to the data port so that fetch wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_conf_q <= PortDm;
    end else if (conflict) begin
      last_conf_q <= gnt_if ? PortIf : PortDm;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported data memory between an instruction-fetch read port and a
// load/store data port.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   if_req/if_addr -> if_gnt            : fetch request and same-cycle accept
//   if_rvalid/if_rdata                  : fetch return, one cycle after the grant
//   dm_req/dm_we/dm_addr/dm_wdata       : data-port request (store when dm_we=1)
//   dm_gnt, dm_rvalid/dm_rdata          : data-port accept and load return
//   mem_en/mem_we/mem_addr/mem_wdata    : memory strobe and command, zero when idle
//   mem_rdata                           : memory read data, one cycle after a read strobe
//   conflict_cnt                        : saturating count of cycles with both requests
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CntW-1:0]   conflict_cnt
);

  logic gnt_if, gnt_dm, conflict;

  mem_arbiter_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (if_req),
    .req_dm   (dm_req),
    .gnt_if   (gnt_if),
    .gnt_dm   (gnt_dm),
    .conflict (conflict)
  );

  assign if_gnt = gnt_if;
  assign dm_gnt = gnt_dm;

  // Memory command mux; grants are already zero in reset, so the strobes follow.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_if) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (gnt_dm) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  // Return tag: which port owns the read data arriving next cycle. Writes leave no tag.
  logic  pend_valid_q, pend_valid_d;
  port_e pend_port_q, pend_port_d;

  always_comb begin
    pend_valid_d = gnt_if | (gnt_dm & ~dm_we);
    pend_port_d  = gnt_dm ? PortDm : PortIf;
  end

  logic [CntW-1:0] conflict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q   <= 1'b0;
      pend_port_q    <= PortIf;
      conflict_cnt_q <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_port_q  <= pend_port_d;
      if (conflict) begin
        conflict_cnt_q <= sat_inc(conflict_cnt_q);
      end
    end
  end

  assign conflict_cnt = conflict_cnt_q;

  always_comb begin
    if_rvalid = pend_valid_q && (pend_port_q == PortIf);
    dm_rvalid = pend_valid_q && (pend_port_q == PortDm);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = dm_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW       = AddrWDefault;
  localparam int unsigned DW       = DataWDefault;
  localparam int unsigned MemWords = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   conflict_cnt;

  mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_gnt       (dm_gnt),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a) * 32'h0101_0003 ^ 32'hA5C3_0000;
  endfunction

  // Memory attached to the DUT: one-cycle read latency.
  logic [DW-1:0] hmem [MemWords];
  initial for (int i = 0; i < MemWords; i++) hmem[i] <= init_word(i);
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) hmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= hmem[mem_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [MemWords];
  port_e         m_last;
  int            m_cnt;
  logic          m_ret_valid;
  port_e         m_ret_port;
  logic [DW-1:0] m_ret_data;

  int n_chk;
  int n_err;

  // Last observed DUT values, for the directed scenarios.
  logic          cap_if_gnt, cap_dm_gnt, cap_mem_we, cap_if_rvalid, cap_dm_rvalid;
  logic [AW-1:0] cap_mem_addr;
  logic [DW-1:0] cap_if_rdata, cap_dm_rdata;
  logic [15:0]   cap_cnt;
  logic          g_if, g_dm;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last      = PortDm;
    m_cnt       = 0;
    m_ret_valid = 1'b0;
    m_ret_port  = PortIf;
    m_ret_data  = '0;
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
  task automatic run_cycle();
    logic          e_if, e_dm, both, r_if, r_dm;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    @(negedge clk);
    both = rst_n && if_req && dm_req;
    if (!rst_n) begin
      e_if = 1'b0;
      e_dm = 1'b0;
    end else if (both) begin
      e_if = (m_last == PortDm);
      e_dm = !e_if;
    end else begin
      e_if = if_req;
      e_dm = dm_req;
    end
    e_en    = e_if || e_dm;
    e_we    = e_dm && dm_we;
    e_addr  = e_if ? if_addr : (e_dm ? dm_addr : '0);
    e_wdata = e_dm ? dm_wdata : '0;
    r_if    = m_ret_valid && (m_ret_port == PortIf);
    r_dm    = m_ret_valid && (m_ret_port == PortDm);

    cap_if_gnt    = if_gnt;
    cap_dm_gnt    = dm_gnt;
    cap_mem_we    = mem_we;
    cap_mem_addr  = mem_addr;
    cap_if_rvalid = if_rvalid;
    cap_dm_rvalid = dm_rvalid;
    cap_if_rdata  = if_rdata;
    cap_dm_rdata  = dm_rdata;
    cap_cnt       = conflict_cnt;

    check_eq("if_gnt", 64'(if_gnt), 64'(e_if));
    check_eq("dm_gnt", 64'(dm_gnt), 64'(e_dm));
    check_eq("mem_en", 64'(mem_en), 64'(e_en));
    check_eq("mem_we", 64'(mem_we), 64'(e_we));
    check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
    if (!e_if) check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    check_eq("if_rvalid", 64'(if_rvalid), 64'(r_if));
    check_eq("if_rdata", 64'(if_rdata), r_if ? 64'(m_ret_data) : 64'd0);
    check_eq("dm_rvalid", 64'(dm_rvalid), 64'(r_dm));
    check_eq("dm_rdata", 64'(dm_rdata), r_dm ? 64'(m_ret_data) : 64'd0);
    check_eq("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (both) begin
        m_last = e_if ? PortIf : PortDm;
        if (m_cnt < 65535) m_cnt++;
      end
      m_ret_valid = e_if || (e_dm && !dm_we);
      m_ret_port  = e_dm ? PortDm : PortIf;
      m_ret_data  = ref_mem[e_addr];
      if (e_dm && dm_we) ref_mem[dm_addr] = dm_wdata;
    end
    g_if = e_if;
    g_dm = e_dm;
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
  endtask

  // Requests are held high during reset to show grants stay forced off.
  task automatic apply_reset(input int cycles);
    rst_n  = 1'b0;
    model_reset();
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int i = 0; i < cycles; i++) run_cycle();
    rst_n = 1'b1;
    idle();
  endtask

  int   rv_count;
  logic [3:0] seq;

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < MemWords; i++) ref_mem[i] = init_word(i);
    if_addr  = '0;
    dm_addr  = '0;
    dm_wdata = '0;
    g_if     = 1'b0;
    g_dm     = 1'b0;
    idle();
    apply_reset(3);

    // Lone fetch: same-cycle grant, data next cycle.
    if_req  = 1'b1;
    if_addr = AW'(12'h004);
    run_cycle();
    check_eq("t_fetch_gnt", 64'(cap_if_gnt), 64'd1);
    check_eq("t_fetch_addr", 64'(cap_mem_addr), 64'h004);
    idle();
    run_cycle();
    check_eq("t_fetch_rvalid", 64'(cap_if_rvalid), 64'd1);
    check_eq("t_fetch_rdata", 64'(cap_if_rdata), 64'(init_word(4)));

    // Four conflict cycles after a fresh reset: IF, DM, IF, DM.
    apply_reset(2);
    if_req  = 1'b1;
    if_addr = AW'(12'h010);
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = AW'(12'h020);
    seq     = '0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      seq = {seq[2:0], cap_if_gnt};
    end
    check_eq("t_conf_seq", 64'(seq), 64'b1010);
    idle();
    run_cycle();
    check_eq("t_conf_cnt", 64'(cap_cnt), 64'd4);

    // Store then load the same word.
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = AW'(12'h030);
    dm_wdata = 32'h0000_000D;
    run_cycle();
    check_eq("t_store_we", 64'(cap_mem_we), 64'd1);
    dm_we = 1'b0;
    run_cycle();
    check_eq("t_store_no_rvalid", 64'(cap_dm_rvalid), 64'd0);
    idle();
    run_cycle();
    check_eq("t_load_rdata", 64'(cap_dm_rdata), 64'h0000_000D);

    // Alternating single-port reads: one return per cycle, no bubbles.
    rv_count = 0;
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i < 6) begin
        if (i % 2 == 0) begin
          if_req  = 1'b1;
          if_addr = AW'(12'h040 + i);
        end else begin
          dm_req  = 1'b1;
          dm_addr = AW'(12'h080 + i);
        end
      end
      run_cycle();
      if (i > 0) rv_count += int'(cap_if_rvalid) + int'(cap_dm_rvalid);
    end
    check_eq("t_alt_returns", 64'(rv_count), 64'd6);

    // Reset in the cycle after a fetch grant: the return is dropped.
    idle();
    if_req = 1'b1;
    dm_req = 1'b1;
    run_cycle();
    idle();
    if_req  = 1'b1;
    if_addr = AW'(12'h050);
    run_cycle();
    apply_reset(2);
    run_cycle();
    check_eq("t_rst_no_rvalid", 64'(cap_if_rvalid), 64'd0);
    check_eq("t_rst_cnt", 64'(cap_cnt), 64'd0);
    if_req = 1'b1;
    dm_req = 1'b1;
    run_cycle();
    check_eq("t_rst_first_conf", 64'(cap_if_gnt), 64'd1);

    // Randomised traffic; an ungranted requester holds its request stable.
    apply_reset(1);
    for (int i = 0; i < 400; i++) begin
      if (!(if_req && !g_if)) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = AW'($urandom_range(0, 15));
      end
      if (!(dm_req && !g_dm)) begin
        dm_req   = 1'($urandom_range(0, 1));
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = AW'($urandom_range(0, 15));
        dm_wdata = DW'($urandom);
      end
      run_cycle();
    end

    // Counter saturation.
    apply_reset(1);
    if_req  = 1'b1;
    if_addr = AW'(12'h100);
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = AW'(12'h200);
    for (int i = 0; i < 65540; i++) run_cycle();
    idle();
    run_cycle();
    check_eq("t_sat_cnt", 64'(cap_cnt), 64'hFFFF);
    if_req = 1'b1;
    dm_req = 1'b1;
    run_cycle();
    run_cycle();
    check_eq("t_sat_hold", 64'(cap_cnt), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
